parser_dispatcher: RTL and testbench

Front-end scheduler that shares a bank of `NUM_PARSERS` `fixed_parser` instances between a single stream of incoming packet headers. It accepts headers over valid/ready, dispatches them round-robin to idle parsers with a one-cycle start pulse, and holds each header stable while its parser runs. It collects the parsed header offsets and returns them in arrival order on a valid/ready output stage, tagged with a sequence number. It sits between the packet header buffer and the match-action pipeline.

---
 rtl/parser_dispatcher.sv | 185 ++++++++++++++++++
 tb/tb_parser_dispatcher.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parser_dispatcher.sv
// Round-robin dispatcher sharing NUM_PARSERS external parsers; results return in accept order.
// Define PARSER_DISP_STATS_EN to enable the accepted-packet and input-stall counters.
module parser_dispatcher #(
    parameter int unsigned         NUM_PARSERS = 4,
    parameter int unsigned         SEQ_W       = 16,
    parameter int unsigned         BYTE_BUS    = 8,
    parameter int unsigned         HDR_MAX_LEN = 16,
    parameter int unsigned         NUM_HEADERS = 3,
    parameter int unsigned         DATA_BUS    = 8,
    parameter logic [DATA_BUS-1:0] NO_HEADER   = '1
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  in_valid_i,
    output logic                                                  in_ready_o,
    input  logic [HDR_MAX_LEN-1:0][BYTE_BUS-1:0]                  in_hdr_i,
    output logic [NUM_PARSERS-1:0]                                par_start_o,
    output logic [NUM_PARSERS-1:0][HDR_MAX_LEN-1:0][BYTE_BUS-1:0] par_hdr_o,
    input  logic [NUM_PARSERS-1:0]                                par_ready_i,
    input  logic [NUM_PARSERS-1:0][NUM_HEADERS-1:0][DATA_BUS-1:0] par_hdrs_i,
    output logic                                                  out_valid_o,
    input  logic                                                  out_ready_i,
    output logic [NUM_HEADERS-1:0][DATA_BUS-1:0]                  out_hdrs_o,
    output logic [SEQ_W-1:0]                                      out_seq_o,
    output logic [31:0]                                           pkt_cnt_o,
    output logic [31:0]                                           stall_cnt_o
);

    localparam int unsigned PtrW = (NUM_PARSERS > 1) ? $clog2(NUM_PARSERS) : 1;

    typedef enum logic [1:0] {StIdle, StStarted, StBusy, StDone} slot_state_e;

    slot_state_e                                        slot_q [NUM_PARSERS];
    slot_state_e                                        slot_d [NUM_PARSERS];
    logic [SEQ_W-1:0]                                   tag_q  [NUM_PARSERS];
    logic [PtrW-1:0]                                    disp_ptr_q, disp_ptr_d;
    logic [PtrW-1:0]                                    ret_ptr_q, ret_ptr_d;
    logic [SEQ_W-1:0]                                   seq_cnt_q;
    logic [NUM_PARSERS-1:0]                             par_start_q, par_start_d;
    logic [NUM_PARSERS-1:0][HDR_MAX_LEN-1:0][BYTE_BUS-1:0] par_hdr_q;
    logic                                               out_valid_q;
    logic [NUM_HEADERS-1:0][DATA_BUS-1:0]               out_hdrs_q;
    logic [SEQ_W-1:0]                                   out_seq_q;

    logic accept;
    logic ret_slot_ready;
    logic out_free;
    logic retire;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (NUM_PARSERS == 1) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    // A BUSY slot whose parser just raised ready can retire directly, skipping DONE.
    always_comb begin
        accept         = in_valid_i && (slot_q[disp_ptr_q] == StIdle);
        ret_slot_ready = ((slot_q[ret_ptr_q] == StBusy) && par_ready_i[ret_ptr_q]) ||
                         (slot_q[ret_ptr_q] == StDone);
        out_free       = !out_valid_q || out_ready_i;
        retire         = ret_slot_ready && out_free;
    end

    // Slot state register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PARSERS; i++) begin
                slot_q[i] <= StIdle;
            end
            disp_ptr_q <= '0;
            ret_ptr_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_PARSERS; i++) begin
                slot_q[i] <= slot_d[i];
            end
            disp_ptr_q <= disp_ptr_d;
            ret_ptr_q  <= ret_ptr_d;
        end
    end

    // Slot next-state logic
    always_comb begin
        disp_ptr_d = accept ? ptr_inc(disp_ptr_q) : disp_ptr_q;
        ret_ptr_d  = retire ? ptr_inc(ret_ptr_q) : ret_ptr_q;
        for (int i = 0; i < NUM_PARSERS; i++) begin
            slot_d[i] = slot_q[i];
            unique case (slot_q[i])
                StIdle: begin
                    if (accept && (disp_ptr_q == PtrW'(i))) begin
                        slot_d[i] = StStarted;
                    end
                end
                // Parser drops ready on the start edge, so ready is not meaningful here.
                StStarted: slot_d[i] = StBusy;
                StBusy: begin
                    if (retire && (ret_ptr_q == PtrW'(i))) begin
                        slot_d[i] = StIdle;
                    end else if (par_ready_i[i]) begin
                        slot_d[i] = StDone;
                    end
                end
                StDone: begin
                    if (retire && (ret_ptr_q == PtrW'(i))) begin
                        slot_d[i] = StIdle;
                    end
                end
                default: slot_d[i] = StIdle;
            endcase
        end
    end

    always_comb begin
        par_start_d = '0;
        if (accept) begin
            par_start_d[disp_ptr_q] = 1'b1;
        end
    end

    // Datapath: per-slot header/tag capture and output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PARSERS; i++) begin
                tag_q[i] <= '0;
            end
            seq_cnt_q   <= '0;
            par_start_q <= '0;
            par_hdr_q   <= '0;
            out_valid_q <= 1'b0;
            out_hdrs_q  <= {NUM_HEADERS{NO_HEADER}};
            out_seq_q   <= '0;
        end else begin
            par_start_q <= par_start_d;
            if (accept) begin
                par_hdr_q[disp_ptr_q] <= in_hdr_i;
                tag_q[disp_ptr_q]     <= seq_cnt_q;
                seq_cnt_q             <= seq_cnt_q + SEQ_W'(1);
            end
            if (retire) begin
                out_valid_q <= 1'b1;
                out_hdrs_q  <= par_hdrs_i[ret_ptr_q];
                out_seq_q   <= tag_q[ret_ptr_q];
            end else if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Outputs come from registered state only.
    always_comb begin
        in_ready_o  = (slot_q[disp_ptr_q] == StIdle);
        par_start_o = par_start_q;
        par_hdr_o   = par_hdr_q;
        out_valid_o = out_valid_q;
        out_hdrs_o  = out_hdrs_q;
        out_seq_o   = out_seq_q;
    end

`ifdef PARSER_DISP_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            if (in_valid_i && !in_ready_o) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign pkt_cnt_o   = pkt_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign pkt_cnt_o   = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_parser_dispatcher.sv
// Directed bench for parser_dispatcher with a behavioural model of four fixed parsers.
module tb_parser_dispatcher;

    localparam int N = 4;
    localparam logic [2:0][7:0] EXP_IPV4  = {8'hFF, 8'd14, 8'd0};
    localparam logic [2:0][7:0] EXP_OTHER = {8'hFF, 8'hFF, 8'd0};
    localparam logic [2:0][7:0] EXP_RST   = {8'hFF, 8'hFF, 8'hFF};

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [15:0][7:0]       in_hdr = '0;
    logic [N-1:0]           par_start;
    logic [N-1:0][15:0][7:0] par_hdr;
    logic [N-1:0]           par_ready;
    logic [N-1:0][2:0][7:0] par_hdrs;
    logic [N-1:0]           par_run;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [2:0][7:0]        out_hdrs;
    logic [15:0]            out_seq;
    logic [31:0]            pkt_cnt;
    logic [31:0]            stall_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [15:0]     seq_q [$];
    logic [2:0][7:0] hdr_q [$];
    int              cyc_q [$];

    parser_dispatcher #(
        .NUM_PARSERS(N),
        .SEQ_W      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_hdr_i   (in_hdr),
        .par_start_o(par_start),
        .par_hdr_o  (par_hdr),
        .par_ready_i(par_ready),
        .par_hdrs_i (par_hdrs),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_hdrs_o (out_hdrs),
        .out_seq_o  (out_seq),
        .pkt_cnt_o  (pkt_cnt),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0][7:0] parse(input logic [15:0][7:0] h);
        logic [2:0][7:0] r;
        r[0] = 8'd0;
        r[1] = (h[12] == 8'h08 && h[13] == 8'h00) ? 8'd14 : 8'hFF;
        r[2] = 8'hFF;
        return r;
    endfunction

    function automatic logic [15:0][7:0] make_hdr(input bit ipv4, input int tag);
        logic [15:0][7:0] h;
        for (int k = 0; k < 16; k++) h[k] = 8'(k + tag);
        h[12] = ipv4 ? 8'h08 : 8'h86;
        h[13] = ipv4 ? 8'h00 : 8'hDD;
        return h;
    endfunction

    // Parser model: ready low the cycle after start, high with results the cycle after that.
    always @(posedge clk) begin
        if (rst) begin
            par_ready <= '1;
            par_run   <= '0;
            par_hdrs  <= {N{EXP_RST}};
        end else begin
            for (int i = 0; i < N; i++) begin
                if (par_start[i]) begin
                    par_ready[i] <= 1'b0;
                    par_run[i]   <= 1'b1;
                end else if (par_run[i]) begin
                    par_ready[i] <= 1'b1;
                    par_run[i]   <= 1'b0;
                    par_hdrs[i]  <= parse(par_hdr[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            seq_q.push_back(out_seq);
            hdr_q.push_back(out_hdrs);
            cyc_q.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        tick();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
        seq_q.delete();
        hdr_q.delete();
        cyc_q.delete();
    endtask

    task automatic wait_results(input string tag, input int n, input int budget);
        int b = 0;
        while (seq_q.size() < n && b < budget) begin
            tick();
            b++;
        end
        check_val(tag, 128'(seq_q.size()), 128'(n));
    endtask

    int acc;
    int vcnt;
    int guard;

    initial begin
        // Reset
        do_reset(3);
        @(negedge clk);
        check_val("rst_in_ready", 128'(in_ready), 128'd1);
        check_val("rst_out_valid", 128'(out_valid), 128'd0);
        check_val("rst_par_start", 128'(par_start), 128'd0);
        check_val("rst_out_seq", 128'(out_seq), 128'd0);
        check_val("rst_out_hdrs", 128'(out_hdrs), 128'(EXP_RST));
        check_val("rst_par_hdr0", 128'(par_hdr[0]), 128'd0);

        // Single IPv4 packet, minimum latency
        tick();
        in_valid = 1'b1;
        in_hdr   = make_hdr(1'b1, 0);
        @(negedge clk);
        check_val("single_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_val("single_start", 128'(par_start), 128'b0001);
        check_val("single_par_hdr", 128'(par_hdr[0]), 128'(make_hdr(1'b1, 0)));
        tick();
        tick();
        @(negedge clk);
        check_val("single_t3_valid", 128'(out_valid), 128'd0);
        tick();
        @(negedge clk);
        check_val("single_t4_valid", 128'(out_valid), 128'd1);
        check_val("single_hdrs", 128'(out_hdrs), 128'(EXP_IPV4));
        check_val("single_seq", 128'(out_seq), 128'd0);
        tick();
        @(negedge clk);
        check_val("single_t5_valid", 128'(out_valid), 128'd0);

        // Eight back-to-back packets, alternating IPv4 / other
        do_reset(1);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            in_valid = 1'b1;
            in_hdr   = make_hdr((k % 2) == 0, k);
            @(negedge clk);
            check_val($sformatf("b2b_ready%0d", k), 128'(in_ready), 128'd1);
        end
        tick();
        in_valid = 1'b0;
        wait_results("b2b_count", 8, 30);
        for (int k = 0; k < 8 && k < seq_q.size(); k++) begin
            check_val($sformatf("b2b_seq%0d", k), 128'(seq_q[k]), 128'(k));
            check_val($sformatf("b2b_hdrs%0d", k), 128'(hdr_q[k]),
                      128'(((k % 2) == 0) ? EXP_IPV4 : EXP_OTHER));
            check_val($sformatf("b2b_cyc%0d", k), 128'(cyc_q[k] - cyc_q[0]), 128'(k));
        end

        // Full backpressure: five accepts then stall; also feeds the stats counters
        do_reset(1);
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 11; c++) begin
            tick();
            in_valid = 1'b1;
            in_hdr   = make_hdr((acc % 2) == 0, acc);
            @(negedge clk);
            if (in_ready) acc++;
        end
        check_val("bp_accepts", 128'(acc), 128'd5);
        check_val("bp_in_ready", 128'(in_ready), 128'd0);
        check_val("bp_out_valid", 128'(out_valid), 128'd1);
        check_val("bp_out_seq", 128'(out_seq), 128'd0);
        check_val("bp_out_hdrs", 128'(out_hdrs), 128'(EXP_IPV4));
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_results("bp_count", 5, 30);
        for (int k = 0; k < 5 && k < seq_q.size(); k++) begin
            check_val($sformatf("bp_seq%0d", k), 128'(seq_q[k]), 128'(k));
            check_val($sformatf("bp_hdrs%0d", k), 128'(hdr_q[k]),
                      128'(((k % 2) == 0) ? EXP_IPV4 : EXP_OTHER));
            check_val($sformatf("bp_cyc%0d", k), 128'(cyc_q[k] - cyc_q[0]), 128'(k));
        end

        // Five more accepts for a total of ten
        acc   = 0;
        guard = 0;
        while (acc < 5 && guard < 20) begin
            tick();
            in_valid = 1'b1;
            in_hdr   = make_hdr(1'b0, 40 + acc);
            @(negedge clk);
            if (in_ready) acc++;
            guard++;
        end
        tick();
        in_valid = 1'b0;
        wait_results("stats_drain", 10, 30);
        @(negedge clk);
`ifdef PARSER_DISP_STATS_EN
        check_val("stats_pkt", 128'(pkt_cnt), 128'd10);
        check_val("stats_stall", 128'(stall_cnt), 128'd6);
`else
        check_val("stats_pkt_off", 128'(pkt_cnt), 128'd0);
        check_val("stats_stall_off", 128'(stall_cnt), 128'd0);
`endif

        // Reset with three packets in flight
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            in_valid = 1'b1;
            in_hdr   = make_hdr(1'b1, 60 + k);
        end
        do_reset(1);
        vcnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
            tick();
        end
        check_val("flush_no_result", 128'(vcnt), 128'd0);
        check_val("flush_in_ready", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_hdr   = make_hdr(1'b0, 70);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_val("flush_start", 128'(par_start), 128'b0001);
        wait_results("flush_count", 1, 20);
        if (seq_q.size() > 0) begin
            check_val("flush_seq", 128'(seq_q[0]), 128'd0);
            check_val("flush_hdrs", 128'(hdr_q[0]), 128'(EXP_OTHER));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
